deserializador: RTL and testbench

Receive-side serial-to-parallel converter with 8b/10b comma alignment. Consumes the synchronized serial bit stream (one bit per `clkRx` cycle) produced by the receiver's 2-FF synchronizer and delivers aligned 10-bit symbols to the downstream 10b/8b decoder. It hunts for K28.5 commas, acquires symbol lock after a run of aligned commas, and drops lock on repeated misaligned commas.

---
 rtl/deser_pkg.sv | 17 +
 rtl/detector_comma.sv | 15 +
 rtl/deserializador.sv | 185 ++++++++++++++++++
 tb/tb_deserializador.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/deser_pkg.sv
// Shared definitions for the receive deserializer and its comma detector.
//   K28_5_RDN / K28_5_RDP : the two running-disparity encodings of K28.5
//   SYM_W                 : 10b symbol width
//   deser_state_t         : alignment state machine encoding
package deser_pkg;

   localparam int SYM_W = 10;
   localparam logic [SYM_W-1:0] K28_5_RDN = 10'h0FA;
   localparam logic [SYM_W-1:0] K28_5_RDP = 10'h305;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      CHECK  = 2'd1,
      LOCKED = 2'd2
   } deser_state_t;

endpackage

// File: rtl/detector_comma.sv
// Combinational K28.5 comma detector.  Kept as its own block so the
// 10b/8b decoder can reuse exactly the same comma definition.
// Ports:
//   W       in  10  candidate symbol, oldest bit in W[9]
//   isComma out  1  W is K28.5 of either running disparity
module detector_comma
   import deser_pkg::*;
(
   input  logic [SYM_W-1:0] W,
   output logic             isComma
);

   assign isComma = (W == K28_5_RDN) || (W == K28_5_RDP);

endmodule

// File: rtl/deserializador.sv
// Serial-to-parallel converter with K28.5 comma alignment.
// Hunts for a comma, confirms LOCK_CNT consecutive aligned commas, then
// emits one aligned 10b symbol every 10 cycles.  UNLOCK_CNT consecutive
// misaligned commas while locked force a new search.
// Optional feature: define DESER_ERRCNT_EN to add the errCnt port, a
// saturating count of misaligned commas seen in CHECK or LOCKED.
// Ports:
//   clkRx    in   1  receive clock, posedge
//   rst      in   1  synchronous active-high reset
//   dataSync in   1  synchronized serial bit, one per cycle
//   dataOut  out 10  aligned symbol, first received bit in [9]
//   validOut out  1  single-cycle strobe, dataOut holds a new symbol
//   commaOut out  1  with validOut: symbol is K28.5
//   locked   out  1  high in LOCKED
//   errCnt   out  8  misaligned-comma count (DESER_ERRCNT_EN only)
//
// state  | meaning
// SEARCH | hunting for any comma, symbol phase unknown
// CHECK  | phase taken from last comma, counting aligned commas
// LOCKED | phase trusted, symbols delivered at every boundary
module deserializador
   import deser_pkg::*;
#(
   parameter int LOCK_CNT   = 3,
   parameter int UNLOCK_CNT = 2
) (
   input  logic             clkRx,
   input  logic             rst,
   input  logic             dataSync,
   output logic [SYM_W-1:0] dataOut,
   output logic             validOut,
   output logic             commaOut,
   output logic             locked
`ifdef DESER_ERRCNT_EN
  ,output logic [7:0]       errCnt
`endif
);

   localparam logic [3:0] LOCK_N   = 4'(LOCK_CNT);
   localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_CNT);

   deser_state_t     state_q, state_d;
   logic [8:0]       sr_q, sr_d;
   logic [3:0]       bit_cnt_q, bit_cnt_d;
   logic [2:0]       good_q, good_d;
   logic [2:0]       bad_q, bad_d;
   logic [SYM_W-1:0] data_out_q, data_out_d;
   logic             valid_out_q, valid_out_d;
   logic             comma_out_q, comma_out_d;
   logic             locked_q, locked_d;

   logic [SYM_W-1:0] win;
   logic             is_comma;
   logic             boundary;
   logic [3:0]       good_inc;
   logic [3:0]       bad_inc;

   // The window includes the bit currently on dataSync, so a symbol is
   // recognised on the same edge that samples its last bit.
   assign win      = {sr_q, dataSync};
   assign boundary = (bit_cnt_q == 4'd9);
   assign good_inc = {1'b0, good_q} + 4'd1;
   assign bad_inc  = {1'b0, bad_q} + 4'd1;

   detector_comma u_detector_comma (
      .W       (win),
      .isComma (is_comma)
   );

   always_comb begin
      sr_d        = {sr_q[7:0], dataSync};
      bit_cnt_d   = boundary ? 4'd0 : bit_cnt_q + 4'd1;
      state_d     = state_q;
      good_d      = good_q;
      bad_d       = bad_q;
      data_out_d  = data_out_q;
      valid_out_d = 1'b0;
      comma_out_d = comma_out_q;
      locked_d    = locked_q;

      case (state_q)
         SEARCH: begin
            if (is_comma) begin
               bit_cnt_d = 4'd0;
               good_d    = 3'd1;
               bad_d     = 3'd0;
               if (LOCK_N == 4'd1) begin
                  state_d  = LOCKED;
                  locked_d = 1'b1;
               end else begin
                  state_d = CHECK;
               end
            end
         end
         CHECK: begin
            if (boundary) begin
               if (is_comma) begin
                  good_d = good_inc[2:0];
                  if (good_inc == LOCK_N) begin
                     state_d  = LOCKED;
                     locked_d = 1'b1;
                     bad_d    = 3'd0;
                  end
               end else begin
                  state_d = SEARCH;
                  good_d  = 3'd0;
               end
            end else if (is_comma) begin
               // Newer comma wins: restart confirmation at its phase.
               bit_cnt_d = 4'd0;
               good_d    = 3'd1;
            end
         end
         LOCKED: begin
            if (boundary) begin
               data_out_d  = win;
               valid_out_d = 1'b1;
               comma_out_d = is_comma;
               if (is_comma) bad_d = 3'd0;
            end else if (is_comma) begin
               if (bad_inc == UNLOCK_N) begin
                  state_d   = SEARCH;
                  bit_cnt_d = 4'd0;
                  locked_d  = 1'b0;
                  bad_d     = 3'd0;
                  good_d    = 3'd0;
               end else begin
                  bad_d = bad_inc[2:0];
               end
            end
         end
         default: begin
            state_d  = SEARCH;
            locked_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clkRx) begin
      if (rst) begin
         state_q     <= SEARCH;
         sr_q        <= '0;
         bit_cnt_q   <= '0;
         good_q      <= '0;
         bad_q       <= '0;
         data_out_q  <= '0;
         valid_out_q <= 1'b0;
         comma_out_q <= 1'b0;
         locked_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         sr_q        <= sr_d;
         bit_cnt_q   <= bit_cnt_d;
         good_q      <= good_d;
         bad_q       <= bad_d;
         data_out_q  <= data_out_d;
         valid_out_q <= valid_out_d;
         comma_out_q <= comma_out_d;
         locked_q    <= locked_d;
      end
   end

   assign dataOut  = data_out_q;
   assign validOut = valid_out_q;
   assign commaOut = comma_out_q;
   assign locked   = locked_q;

`ifdef DESER_ERRCNT_EN
   logic [7:0] err_cnt_q, err_cnt_d;

   always_comb begin
      err_cnt_d = err_cnt_q;
      if ((state_q != SEARCH) && is_comma && !boundary && (err_cnt_q != 8'hFF))
         err_cnt_d = err_cnt_q + 8'd1;
   end

   always_ff @(posedge clkRx) begin
      if (rst) err_cnt_q <= '0;
      else     err_cnt_q <= err_cnt_d;
   end

   assign errCnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_deserializador.sv
// Self-checking bench for deserializador (default LOCK_CNT=3, UNLOCK_CNT=2).
// Expected symbols are queued when sent; a negedge monitor pops one per
// validOut pulse.  An empty queue at a pulse is an unexpected symbol.
module tb_deserializador;

   logic       clkRx    = 1'b0;
   logic       rst      = 1'b1;
   logic       dataSync = 1'b0;
   logic [9:0] dataOut;
   logic       validOut;
   logic       commaOut;
   logic       locked;
`ifdef DESER_ERRCNT_EN
   logic [7:0] errCnt;
`endif

   int checks   = 0;
   int failures = 0;
   int valid_cnt = 0;
   logic [10:0] sb_q[$];
   logic [10:0] mon_exp;

   deserializador dut (
      .clkRx    (clkRx),
      .rst      (rst),
      .dataSync (dataSync),
      .dataOut  (dataOut),
      .validOut (validOut),
      .commaOut (commaOut),
      .locked   (locked)
`ifdef DESER_ERRCNT_EN
     ,.errCnt   (errCnt)
`endif
   );

   always #5 clkRx = ~clkRx;

   always @(negedge clkRx) begin
      if (validOut === 1'b1) begin
         valid_cnt++;
         checks++;
         if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_valid got dataOut=%h commaOut=%b, required no symbol",
                     dataOut, commaOut);
         end else begin
            mon_exp = sb_q.pop_front();
            if ({commaOut, dataOut} !== mon_exp) begin
               failures++;
               $display("FAIL symbol got dataOut=%h commaOut=%b, required dataOut=%h commaOut=%b",
                        dataOut, commaOut, mon_exp[9:0], mon_exp[10]);
            end
         end
      end
   end

   task automatic send_bit(input logic b);
      dataSync = b;
      @(posedge clkRx);
      #1;
   endtask

   task automatic send_sym(input logic [9:0] s, input bit push, input bit cm);
      if (push) sb_q.push_back({cm, s});
      for (int i = 9; i >= 0; i--) send_bit(s[i]);
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      dataSync = 1'b0;
      repeat (n) @(posedge clkRx);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset;
      repeat (3) @(posedge clkRx);
      #1;
      checks++;
      if ({dataOut, validOut, commaOut, locked} !== 13'd0) begin
         failures++;
         $display("FAIL reset_outputs got %h/%b/%b/%b, required all zero",
                  dataOut, validOut, commaOut, locked);
      end
`ifdef DESER_ERRCNT_EN
      checks++;
      if (errCnt !== 8'd0) begin
         failures++;
         $display("FAIL reset_errcnt got %h, required 00", errCnt);
      end
`endif
      rst = 1'b0;
   endtask

   task automatic test_lock;
      logic [9:0] syms[5];
      int v0;
      syms = '{10'h0FA, 10'h305, 10'h0FA, 10'h305, 10'h0FA};
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      v0 = valid_cnt;
      for (int i = 0; i < 5; i++) begin
         send_sym(syms[i], i >= 3, 1'b1);
         checks++;
         if (locked !== (i >= 2)) begin
            failures++;
            $display("FAIL lock_comma%0d got locked=%b, required %b", i + 1, locked, i >= 2);
         end
      end
      @(negedge clkRx); #1;
      checks++;
      if (valid_cnt - v0 != 2) begin
         failures++;
         $display("FAIL lock_valid_count got %0d, required 2", valid_cnt - v0);
      end
   endtask

   task automatic test_data;
      int v0;
      v0 = valid_cnt;
      for (int i = 0; i < 5; i++) begin
         send_sym(10'h2AA, 1'b1, 1'b0);
         checks++;
         if (locked !== 1'b1) begin
            failures++;
            $display("FAIL data_locked sym%0d got %b, required 1", i, locked);
         end
      end
      @(negedge clkRx); #1;
      checks++;
      if (valid_cnt - v0 != 5) begin
         failures++;
         $display("FAIL data_valid_count got %0d, required 5", valid_cnt - v0);
      end
   endtask

   task automatic test_misalign;
      int v0;
      v0 = valid_cnt;
      // Boundary windows straddling the 4-bit slip.
      sb_q.push_back({1'b0, 10'h14F});
      sb_q.push_back({1'b0, 10'h2B0});
      send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      send_sym(10'h0FA, 1'b0, 1'b0);
      checks++;
      if (locked !== 1'b1) begin
         failures++;
         $display("FAIL misalign_first got locked=%b, required 1", locked);
      end
      send_sym(10'h305, 1'b0, 1'b0);
      checks++;
      if (locked !== 1'b0) begin
         failures++;
         $display("FAIL misalign_second got locked=%b, required 0", locked);
      end
      @(negedge clkRx); #1;
      checks++;
      if (valid_cnt - v0 != 2) begin
         failures++;
         $display("FAIL misalign_valid_count got %0d, required 2", valid_cnt - v0);
      end
`ifdef DESER_ERRCNT_EN
      checks++;
      if (errCnt !== 8'd2) begin
         failures++;
         $display("FAIL misalign_errcnt got %h, required 02", errCnt);
      end
`endif
      send_sym(10'h0FA, 1'b0, 1'b0);
      send_sym(10'h305, 1'b0, 1'b0);
      checks++;
      if (locked !== 1'b0) begin
         failures++;
         $display("FAIL relock_early got locked=%b, required 0", locked);
      end
      send_sym(10'h0FA, 1'b0, 1'b0);
      checks++;
      if (locked !== 1'b1) begin
         failures++;
         $display("FAIL relock got locked=%b, required 1", locked);
      end
      send_sym(10'h305, 1'b1, 1'b1);
      @(negedge clkRx); #1;
   endtask

   task automatic test_check_fail;
      int v0;
      do_reset(1);
      v0 = valid_cnt;
      send_sym(10'h0FA, 1'b0, 1'b0);
      send_sym(10'h305, 1'b0, 1'b0);
      send_sym(10'h155, 1'b0, 1'b0);
      checks++;
      if (locked !== 1'b0) begin
         failures++;
         $display("FAIL check_fail_locked got %b, required 0", locked);
      end
      // Still in CHECK with two good commas, this one would lock.
      send_sym(10'h0FA, 1'b0, 1'b0);
      checks++;
      if (locked !== 1'b0) begin
         failures++;
         $display("FAIL check_fail_returned_search got locked=%b, required 0", locked);
      end
      send_sym(10'h2AA, 1'b0, 1'b0);
      send_sym(10'h2AA, 1'b0, 1'b0);
      @(negedge clkRx); #1;
      checks++;
      if (valid_cnt != v0) begin
         failures++;
         $display("FAIL check_fail_no_valid got %0d pulses, required 0", valid_cnt - v0);
      end
   endtask

   task automatic test_reset_mid;
      do_reset(1);
      send_sym(10'h0FA, 1'b0, 1'b0);
      send_sym(10'h305, 1'b0, 1'b0);
      send_sym(10'h0FA, 1'b0, 1'b0);
      checks++;
      if (locked !== 1'b1) begin
         failures++;
         $display("FAIL reset_mid_prelock got %b, required 1", locked);
      end
      send_sym(10'h305, 1'b1, 1'b1);
      @(negedge clkRx); #1;
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      rst = 1'b1;
      dataSync = 1'b0;
      @(posedge clkRx); #1;
      rst = 1'b0;
      checks++;
      if ({dataOut, validOut, commaOut, locked} !== 13'd0) begin
         failures++;
         $display("FAIL reset_mid_outputs got %h/%b/%b/%b, required all zero",
                  dataOut, validOut, commaOut, locked);
      end
`ifdef DESER_ERRCNT_EN
      checks++;
      if (errCnt !== 8'd0) begin
         failures++;
         $display("FAIL reset_mid_errcnt got %h, required 00", errCnt);
      end
`endif
      send_sym(10'h0FA, 1'b0, 1'b0);
      send_sym(10'h305, 1'b0, 1'b0);
      checks++;
      if (locked !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_restart got locked=%b, required 0", locked);
      end
   endtask

   // Each group carries one comma straddling two slots, followed by an
   // aligned comma that clears the misalignment run, so lock holds.
   task automatic test_saturate;
      do_reset(1);
      send_sym(10'h0FA, 1'b0, 1'b0);
      send_sym(10'h305, 1'b0, 1'b0);
      send_sym(10'h0FA, 1'b0, 1'b0);
      for (int g = 1; g <= 300; g++) begin
         send_sym(10'h2A7, 1'b1, 1'b0);
         send_sym(10'h355, 1'b1, 1'b0);
         send_sym(10'h305, 1'b1, 1'b1);
         if (g == 1 || g == 300) begin
            checks++;
            if (locked !== 1'b1) begin
               failures++;
               $display("FAIL sat_locked group%0d got %b, required 1", g, locked);
            end
         end
`ifdef DESER_ERRCNT_EN
         if (g == 1 || g == 254 || g == 255 || g == 300) begin
            checks++;
            if (errCnt !== ((g > 255) ? 8'hFF : 8'(g))) begin
               failures++;
               $display("FAIL sat_errcnt group%0d got %h, required %h",
                        g, errCnt, (g > 255) ? 8'hFF : 8'(g));
            end
         end
`endif
      end
      @(negedge clkRx); #1;
   endtask

   initial begin
      test_reset;
      test_lock;
      test_data;
      test_misalign;
      test_check_fail;
      test_reset_mid;
      test_saturate;
      checks++;
      if (sb_q.size() != 0) begin
         failures++;
         $display("FAIL missing_symbols got %0d undelivered, required 0", sb_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
